// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
//   Shared definitions for the OLED display sequencing logic: the phase
//   encoding used by the sequencer FSM, data/counter widths and the SSD1306
//   IIC slave address that every sequencer embeds in its 24-bit words.
// -----------------------------------------------------------------------------
package oled_pkg;

    // One IIC word is {slave addr, control byte, data byte}.
    localparam int DATA_W = 24;

    // Watchdog counter width; wide enough for a 5e6-cycle limit.
    localparam int WD_W = 23;

    // 7-bit address 0x3C shifted left with the write bit clear.
    localparam logic [7:0] OLED_IIC_ADDR = 8'h78;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_SHOW  = 3'd3,
        ST_WAIT  = 3'd4
    } oled_state_t;

    // True for the phases that own the IIC writer.
    function automatic logic state_owns_iic(oled_state_t s);
        return (s == ST_INIT) || (s == ST_CLEAR) || (s == ST_SHOW);
    endfunction

endpackage

// File: rtl/oled_wdog.sv
// -----------------------------------------------------------------------------
// oled_wdog
//   Free-running stall detector for the IIC writer. Counts clock cycles while
//   'run' is high; 'kick' restarts the count. 'expire' is asserted
//   combinationally on the last cycle of the allowed window so the owner can
//   react on the very next clock edge.
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   run     in   count enable (IIC writer busy)
//   kick    in   synchronous counter clear, has priority over counting
//   expire  out  high while running with the count at WD_CYCLES-1
// -----------------------------------------------------------------------------
module oled_wdog
    import oled_pkg::*;
#(
    parameter int unsigned WD_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (kick) begin
            wd_cnt <= '0;
        end else if (run && (wd_cnt != WD_LAST)) begin
            // Saturate at the limit so a missing kick cannot wrap around.
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign expire = run && (wd_cnt == WD_LAST);

endmodule

// File: rtl/oled_seq_ctrl.sv
// -----------------------------------------------------------------------------
// oled_seq_ctrl
//   Top-level phase sequencer for the temperature/humidity OLED display.
//   After a power-up delay it hands the shared IIC writer to the init
//   sequencer, then the screen-clear sequencer, then the digit renderer
//   whenever a new sensor sample (or the very first draw) is pending.
//   A watchdog on write_done restarts the panel from INIT if the writer stalls.
//
// Ports
//   sys_clk        in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   dht11_done     in   pulse: new sensor sample available
//   init_data      in   24-bit word from the init sequencer
//   init_finish    in   pulse with the init sequencer's last write_done
//   clear_data     in   24-bit word from the clear sequencer
//   clear_finish   in   pulse with the clear sequencer's last write_done
//   show_data      in   24-bit word from the digit renderer
//   show_finish    in   pulse with the renderer's last write_done
//   write_done     in   pulse: IIC writer finished one word
//   init_req       out  init phase active
//   clear_req      out  clear phase active
//   show_req       out  show phase active
//   init_wdone     out  write_done gated to the init sequencer
//   clear_wdone    out  write_done gated to the clear sequencer
//   show_wdone     out  write_done gated to the digit renderer
//   iic_req        out  IIC writer request (any phase active)
//   iic_data       out  word of the active phase, zero when idle
//   ready          out  high once a screen clear has completed
//   err            out  sticky watchdog flag
// -----------------------------------------------------------------------------
module oled_seq_ctrl
    import oled_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 1000000,
    parameter int unsigned WD_CYCLES      = 5000000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              dht11_done,
    input  logic [DATA_W-1:0] init_data,
    input  logic              init_finish,
    input  logic [DATA_W-1:0] clear_data,
    input  logic              clear_finish,
    input  logic [DATA_W-1:0] show_data,
    input  logic              show_finish,
    input  logic              write_done,
    output logic              init_req,
    output logic              clear_req,
    output logic              show_req,
    output logic              init_wdone,
    output logic              clear_wdone,
    output logic              show_wdone,
    output logic              iic_req,
    output logic [DATA_W-1:0] iic_data,
    output logic              ready,
    output logic              err
);

    localparam int PW_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(POWERUP_CYCLES - 1);

    oled_state_t     state;
    oled_state_t     state_nxt;
    logic [PW_W-1:0] pwr_cnt;
    logic            refresh_pend;
    logic            clear_done;
    logic            show_entry;
    logic            state_chg;
    logic            wd_kick;
    logic            wd_expire;

    // -------------------------------------------------------------------------
    // Next-state logic. Only the active phase's finish is honoured; finishes
    // from the other requesters fall through the case untouched.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        clear_done = 1'b0;
        show_entry = 1'b0;
        case (state)
            ST_PWRUP: if (pwr_cnt == PW_LAST) state_nxt = ST_INIT;
            ST_INIT:  if (init_finish)        state_nxt = ST_CLEAR;
            ST_CLEAR: if (clear_finish)       state_nxt = ST_WAIT;
            ST_SHOW:  if (show_finish)        state_nxt = ST_WAIT;
            // A sample arriving in WAIT starts SHOW on the next edge without
            // first passing through the pending flag.
            ST_WAIT:  if (refresh_pend || dht11_done) state_nxt = ST_SHOW;
            default:  state_nxt = ST_PWRUP;
        endcase

        // Stalled writer: restart the panel; overrides any finish this cycle.
        if (wd_expire) state_nxt = ST_INIT;

        clear_done = (state == ST_CLEAR) && (state_nxt == ST_WAIT);
        show_entry = (state == ST_WAIT)  && (state_nxt == ST_SHOW);
        state_chg  = (state_nxt != state);
    end

    // -------------------------------------------------------------------------
    // State, registered request decodes, power-up timer, flags.
    // Requests are decoded from state_nxt so they rise with the state itself.
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_PWRUP;
            init_req     <= 1'b0;
            clear_req    <= 1'b0;
            show_req     <= 1'b0;
            pwr_cnt      <= '0;
            refresh_pend <= 1'b0;
            ready        <= 1'b0;
            err          <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_req  <= (state_nxt == ST_INIT);
            clear_req <= (state_nxt == ST_CLEAR);
            show_req  <= (state_nxt == ST_SHOW);

            if ((state == ST_PWRUP) && (pwr_cnt != PW_LAST)) begin
                pwr_cnt <= pwr_cnt + 1'b1;
            end

            // Single-deep refresh queue. Entering SHOW consumes it; the first
            // WAIT after a clear queues one draw so digits appear immediately.
            if (show_entry) begin
                refresh_pend <= 1'b0;
            end else if (dht11_done || clear_done) begin
                refresh_pend <= 1'b1;
            end

            if (wd_expire) begin
                err   <= 1'b1;
                ready <= 1'b0;
            end else if (clear_done) begin
                ready <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // IIC writer interface
    // -------------------------------------------------------------------------
    assign iic_req     = init_req | clear_req | show_req;
    assign init_wdone  = write_done & init_req;
    assign clear_wdone = write_done & clear_req;
    assign show_wdone  = write_done & show_req;

    always_comb begin
        iic_data = '0;
        case (state)
            ST_INIT:  iic_data = init_data;
            ST_CLEAR: iic_data = clear_data;
            ST_SHOW:  iic_data = show_data;
            default:  iic_data = '0;
        endcase
    end

    // The count restarts on every completed word and on every phase change,
    // so it measures the gap since the writer last made progress.
    assign wd_kick = write_done | state_chg | wd_expire;

    oled_wdog #(
        .WD_CYCLES (WD_CYCLES)
    ) u_wdog (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .run    (iic_req),
        .kick   (wd_kick),
        .expire (wd_expire)
    );

endmodule

// File: doc/oled_seq_ctrl.md
OLED_SEQ_CTRL -- requirements
Module: oled_seq_ctrl

Interface
REQ-001 Parameter POWERUP_CYCLES, default 1000000, is the number of sys_clk cycles to wait after reset before the first IIC write (20 ms at 50 MHz).
REQ-002 Parameter WD_CYCLES, default 5000000, is the write_done watchdog limit in sys_clk cycles.
REQ-003 sys_clk input 1: single clock; one clock, all logic on its rising edge.
REQ-004 rst_n input 1: asynchronous, active-low reset.
REQ-005 dht11_done input 1: pulse meaning a new sensor sample is available.
REQ-006 init_data input 24: {addr, ctrl, byte} word from the init sequencer; init_finish input 1: pulse coincident with its last write_done.
REQ-007 clear_data input 24 and clear_finish input 1: same as REQ-006, for the screen-clear sequencer.
REQ-008 show_data input 24 and show_finish input 1: same as REQ-006, for the digit renderer.
REQ-009 write_done input 1: IIC writer pulse, one 24-bit word completed.
REQ-010 init_req, clear_req, show_req output 1 each: phase request, held high for the whole phase.
REQ-011 init_wdone, clear_wdone, show_wdone output 1 each: write_done routed to the active requester only.
REQ-012 iic_req output 1 and iic_data output 24: IIC writer request and word.
REQ-013 ready output 1: high once the first clear has completed.
REQ-014 err output 1: sticky watchdog flag.

Function
REQ-015 FSM states SHALL be: PWRUP, INIT, CLEAR, SHOW, WAIT.
REQ-016 PWRUP SHALL count to POWERUP_CYCLES-1, then go to INIT.
REQ-017 INIT SHALL go to CLEAR on init_finish; CLEAR to WAIT on clear_finish (setting ready); SHOW to WAIT on show_finish.
REQ-018 WAIT SHALL go to SHOW when the refresh-pending flag is set, clearing the flag on entry.
REQ-019 The refresh-pending flag SHALL set on dht11_done in any state and clear only on SHOW entry, so at most one refresh is queued and a sample during SHOW causes exactly one further SHOW.
REQ-020 The first entry to WAIT after CLEAR SHALL set refresh-pending, so digits are drawn once without a sensor sample.
REQ-021 Request outputs SHALL be registered decodes of state (INIT, CLEAR, SHOW), asserted in the same cycle as state entry.
REQ-022 iic_req SHALL equal init_req|clear_req|show_req.
REQ-023 iic_data SHALL be a combinational mux of the active requester's data, and 24'h0 in PWRUP and WAIT.
REQ-024 The x_wdone outputs SHALL equal write_done ANDed with x_req; write_done in PWRUP or WAIT SHALL be ignored.
REQ-025 A finish pulse from a non-active requester SHALL be ignored.
REQ-026 Watchdog: a 23-bit counter SHALL run while iic_req is high and clear on write_done or on any state change.
REQ-027 On reaching WD_CYCLES-1 the watchdog SHALL set err, clear ready, and force INIT next cycle; refresh-pending is unchanged.
REQ-028 A finish and a watchdog expiry in the same cycle: watchdog SHALL win.
REQ-029 Phase transitions SHALL take effect one cycle after the finish pulse, and the new request SHALL be high in that same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously set: state PWRUP, all counters 0, refresh-pending 0.
REQ-031 rst_n low SHALL asynchronously set all req outputs 0, ready 0 and err 0.
REQ-032 Reset mid-phase SHALL abort immediately, with no further iic_req until PWRUP completes again.

Structure
REQ-033 The state encoding and the IIC address constant 8'h78 SHALL live in the shared oled_pkg.
REQ-034 The watchdog counter SHALL be a sub-module oled_wdog with ports clk, rst_n, run, kick, expire, parameterised by WD_CYCLES.

Verification
REQ-035 POWERUP_CYCLES=8: release reset -> init_req rises exactly on cycle 8, and iic_req=0 before that.
REQ-036 Model init=3 writes, clear=4 writes, show=2 writes -> state sequence INIT->CLEAR->WAIT->SHOW->WAIT, ready=1 after clear_finish, exactly 9 wdone pulses.
REQ-037 dht11_done twice during SHOW -> exactly one extra SHOW; dht11_done in WAIT -> show_req high 1 cycle later.
REQ-038 WD_CYCLES=16, write_done held low in CLEAR -> err=1 and ready=0 at cycle 16, then init_req=1.
REQ-039 Spurious clear_finish and write_done during SHOW -> clear_wdone stays 0 and the state is unchanged.
REQ-040 rst_n low during SHOW -> all outputs 0 asynchronously, then PWRUP restarts.
